// File: rtl/mult_accumulator.sv
// Frame accumulator for the multiplier product stream: sums products until last_i or MAX_LEN.
// Optional build macro MULT_ACC_SAT_EN clamps the frame sum instead of wrapping.
module mult_accumulator #(
  parameter int unsigned P_WIDTH   = 11,
  parameter int unsigned ACC_WIDTH = 13,
  parameter int unsigned MAX_LEN   = 8,
  parameter int unsigned CNT_W     = 4
) (
  input  logic                 clk_i,
  input  logic                 reset_an_i,
  input  logic                 reset_i,
  input  logic                 stall_i,
  input  logic                 valid_i,
  input  logic                 last_i,
  input  logic [P_WIDTH-1:0]   data_p_i,
  output logic [ACC_WIDTH-1:0] sum_o,
  output logic [CNT_W-1:0]     count_o,
  output logic                 overflow_o,
  output logic                 trunc_o,
  output logic                 sum_valid_o
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ACCUM = 1'b1;
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = '1;

  logic [0:0]           r_state;
  logic [ACC_WIDTH-1:0] r_acc;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_ovf;
  logic [ACC_WIDTH-1:0] r_sum;
  logic [CNT_W-1:0]     r_count;
  logic                 r_ovf_out;
  logic                 r_trunc;
  logic                 r_valid;

  logic                 w_accept;
  logic                 w_close;
  logic [ACC_WIDTH:0]   w_data_ext;
  logic [ACC_WIDTH:0]   w_sum_wide;
  logic [ACC_WIDTH-1:0] w_acc_next;
  logic [CNT_W-1:0]     w_cnt_next;
  logic                 w_ovf_next;

  assign w_accept   = valid_i & ~stall_i;
  assign w_data_ext = (ACC_WIDTH + 1)'(data_p_i);

  always_comb begin
    w_sum_wide = '0;
    w_cnt_next = '0;
    w_ovf_next = 1'b0;
    if (r_state == S_IDLE) begin
      w_sum_wide = w_data_ext;
      w_cnt_next = CNT_W'(1);
      w_ovf_next = 1'b0;
    end else begin
      w_sum_wide = {1'b0, r_acc} + w_data_ext;
      w_cnt_next = r_cnt + CNT_W'(1);
      w_ovf_next = r_ovf | w_sum_wide[ACC_WIDTH];
    end
`ifdef MULT_ACC_SAT_EN
    // Once overflowed the accumulator sits at full scale for the rest of the frame.
    w_acc_next = w_ovf_next ? ACC_MAX : w_sum_wide[ACC_WIDTH-1:0];
`else
    w_acc_next = w_sum_wide[ACC_WIDTH-1:0];
`endif
  end

  assign w_close = w_accept & (last_i | (w_cnt_next == CNT_W'(MAX_LEN)));

  always_ff @(posedge clk_i or negedge reset_an_i) begin
    if (!reset_an_i) begin
      r_state   <= S_IDLE;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
      r_sum     <= '0;
      r_count   <= '0;
      r_ovf_out <= 1'b0;
      r_trunc   <= 1'b0;
      r_valid   <= 1'b0;
    end else if (reset_i) begin
      r_state   <= S_IDLE;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
      r_sum     <= '0;
      r_count   <= '0;
      r_ovf_out <= 1'b0;
      r_trunc   <= 1'b0;
      r_valid   <= 1'b0;
    end else if (!stall_i) begin
      r_valid <= w_close;
      if (w_close) begin
        r_sum     <= w_acc_next;
        r_count   <= w_cnt_next;
        r_ovf_out <= w_ovf_next;
        r_trunc   <= ~last_i;
        r_state   <= S_IDLE;
        r_acc     <= '0;
        r_cnt     <= '0;
        r_ovf     <= 1'b0;
      end else if (w_accept) begin
        r_state <= S_ACCUM;
        r_acc   <= w_acc_next;
        r_cnt   <= w_cnt_next;
        r_ovf   <= w_ovf_next;
      end
    end
  end

  assign sum_o       = r_sum;
  assign count_o     = r_count;
  assign overflow_o  = r_ovf_out;
  assign trunc_o     = r_trunc;
  assign sum_valid_o = r_valid;

endmodule

// File: tb/tb_mult_accumulator.sv
// Randomised and directed bench for mult_accumulator against a frame-level sum model.
// Honours MULT_ACC_SAT_EN the same way the design does.
module tb_mult_accumulator;

  localparam int unsigned P_WIDTH   = 11;
  localparam int unsigned ACC_WIDTH = 13;
  localparam int unsigned MAX_LEN   = 8;
  localparam int unsigned CNT_W     = 4;
  localparam longint     ACC_FULL  = (64'd1 << ACC_WIDTH) - 1;

  logic                 clk_i = 1'b0;
  logic                 reset_an_i = 1'b0;
  logic                 reset_i = 1'b0;
  logic                 stall_i = 1'b0;
  logic                 valid_i = 1'b0;
  logic                 last_i = 1'b0;
  logic [P_WIDTH-1:0]   data_p_i = '0;
  logic [ACC_WIDTH-1:0] sum_o;
  logic [CNT_W-1:0]     count_o;
  logic                 overflow_o;
  logic                 trunc_o;
  logic                 sum_valid_o;

  mult_accumulator #(
    .P_WIDTH  (P_WIDTH),
    .ACC_WIDTH(ACC_WIDTH),
    .MAX_LEN  (MAX_LEN),
    .CNT_W    (CNT_W)
  ) u_dut (
    .clk_i      (clk_i),
    .reset_an_i (reset_an_i),
    .reset_i    (reset_i),
    .stall_i    (stall_i),
    .valid_i    (valid_i),
    .last_i     (last_i),
    .data_p_i   (data_p_i),
    .sum_o      (sum_o),
    .count_o    (count_o),
    .overflow_o (overflow_o),
    .trunc_o    (trunc_o),
    .sum_valid_o(sum_valid_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: products of the open frame plus the last published result.
  int     frame_q[$];
  longint exp_sum;
  int     exp_cnt;
  bit     exp_ovf;
  bit     exp_trunc;
  bit     exp_valid;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    frame_q.delete();
    exp_sum = 0; exp_cnt = 0; exp_ovf = 0; exp_trunc = 0; exp_valid = 0;
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, "_sum"},   32'(sum_o),       32'(exp_sum));
    check_eq({tag, "_cnt"},   32'(count_o),     32'(exp_cnt));
    check_eq({tag, "_ovf"},   32'(overflow_o),  32'(exp_ovf));
    check_eq({tag, "_trunc"}, 32'(trunc_o),     32'(exp_trunc));
    check_eq({tag, "_valid"}, 32'(sum_valid_o), 32'(exp_valid));
  endtask

  task automatic cycle(input logic v, input logic l, input logic [P_WIDTH-1:0] d,
                       input logic st, input logic rs, input string tag);
    longint total;
    valid_i = v; last_i = l; data_p_i = d; stall_i = st; reset_i = rs;
    @(posedge clk_i);
    if (rs) begin
      model_clear();
    end else if (!st) begin
      exp_valid = 0;
      if (v) begin
        frame_q.push_back(int'(d));
        if (l || frame_q.size() == MAX_LEN) begin
          total = 0;
          foreach (frame_q[i]) total += longint'(frame_q[i]);
          exp_ovf = total > ACC_FULL;
`ifdef MULT_ACC_SAT_EN
          exp_sum = exp_ovf ? ACC_FULL : total;
`else
          exp_sum = total % (ACC_FULL + 1);
`endif
          exp_cnt   = frame_q.size();
          exp_trunc = !l;
          exp_valid = 1;
          frame_q.delete();
        end
      end
    end
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, tag);
  endtask

  initial begin
    model_clear();
    #2;
    check_all("rst");
    @(negedge clk_i);
    reset_an_i = 1'b1;

    // 3,5,7 -> 15
    cycle(1, 0, 3, 0, 0, "f1a");
    cycle(1, 0, 5, 0, 0, "f1b");
    cycle(1, 1, 7, 0, 0, "f1c");
    check_eq("f1_sum", 32'(sum_o), 15);
    check_eq("f1_valid", 32'(sum_valid_o), 1);
    idle("f1_drop");
    check_eq("f1_pulse_len", 32'(sum_valid_o), 0);

    // Back-to-back frames with no bubble
    cycle(1, 1, 2047, 0, 0, "b2b1");
    check_eq("b2b1_sum", 32'(sum_o), 2047);
    cycle(1, 0, 1, 0, 0, "b2b2");
    cycle(1, 1, 1, 0, 0, "b2b3");
    check_eq("b2b_sum", 32'(sum_o), 2);

    // Overflow over five full-scale products
    for (int i = 0; i < 5; i++) cycle(1, i == 4, 2047, 0, 0, "ovf");
`ifdef MULT_ACC_SAT_EN
    check_eq("ovf_sum", 32'(sum_o), 8191);
`else
    check_eq("ovf_sum", 32'(sum_o), 2043);
`endif
    check_eq("ovf_flag", 32'(overflow_o), 1);

    // Forced close at MAX_LEN
    for (int i = 0; i < 9; i++) begin
      cycle(1, 0, 1, 0, 0, "trunc");
      if (i == 7) begin
        check_eq("trunc_sum", 32'(sum_o), 8);
        check_eq("trunc_cnt", 32'(count_o), 8);
        check_eq("trunc_flag", 32'(trunc_o), 1);
      end
    end
    cycle(1, 1, 1, 0, 0, "trunc_next");
    check_eq("trunc_next_cnt", 32'(count_o), 2);

    // Stall freezes accumulation
    cycle(1, 0, 10, 0, 0, "stl");
    cycle(1, 0, 20, 0, 0, "stl");
    for (int i = 0; i < 3; i++) cycle(1, 0, 999, 1, 0, "stl_hold");
    cycle(1, 1, 30, 0, 0, "stl_end");
    check_eq("stl_sum", 32'(sum_o), 60);
    check_eq("stl_cnt", 32'(count_o), 3);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 1, 0, "stl_pulse");
      check_eq("stl_pulse_held", 32'(sum_valid_o), 1);
    end
    idle("stl_pulse_drop");

    // Async reset mid-frame
    cycle(1, 0, 4, 0, 0, "ar");
    cycle(1, 0, 4, 0, 0, "ar");
    valid_i = 0; last_i = 0;
    @(negedge clk_i);
    reset_an_i = 1'b0;
    #1;
    model_clear();
    check_all("ar_now");
    @(negedge clk_i);
    reset_an_i = 1'b1;
    cycle(1, 1, 4, 0, 0, "ar_after");
    check_eq("ar_after_sum", 32'(sum_o), 4);
    check_eq("ar_after_cnt", 32'(count_o), 1);

    // Sync clear mid-frame, taking priority over stall
    cycle(1, 0, 4, 0, 0, "sr");
    cycle(1, 0, 4, 0, 0, "sr");
    cycle(1, 0, 4, 1, 1, "sr_clr");
    cycle(1, 1, 4, 0, 0, "sr_after");
    check_eq("sr_after_sum", 32'(sum_o), 4);
    check_eq("sr_after_cnt", 32'(count_o), 1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic [P_WIDTH-1:0] d;
      d = ($urandom_range(0, 3) == 0) ? P_WIDTH'(2047) : P_WIDTH'($urandom);
      cycle(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 5) == 0), d,
            logic'($urandom_range(0, 5) == 0), logic'($urandom_range(0, 60) == 0), "rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
